// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider: minimum period,
// configuration FSM states and the range-clamp helper.
package clk_div_pkg;

    localparam logic [31:0] DIV_MIN = 32'd2;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_WRAP = 1'b1
    } cfg_state_e;

    // Works on 32-bit values so any channel width up to 32 bits can share it.
    function automatic logic [31:0] clampU32(input logic [31:0] value,
                                             input logic [31:0] lo,
                                             input logic [31:0] hi);
        if (value < lo) begin
            return lo;
        end
        if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period, high count and counter, with registered
// clock and end-of-period tick outputs plus a load port for new settings.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 50000000
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] loadDiv_i,
    input  logic [CNT_W-1:0] loadHi_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             atWrap_o
);

    localparam logic [CNT_W-1:0] RESET_P  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] RESET_HI = CNT_W'(DEFAULT_DIV >> 1);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;

    assign atWrap_o  = (cnt_q == period_q - CNT_W'(1));
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

    // A load only arrives at a wrap or while idle, so the period in progress
    // always finishes with the old settings and the new ones start at CNT=0.
    always_comb begin
        period_d = period_q;
        high_d   = high_q;
        cnt_d    = cnt_q;
        clk_d    = 1'b0;
        tick_d   = 1'b0;
        if (load_i) begin
            period_d = loadDiv_i;
            high_d   = loadHi_i;
        end
        if (!enable_i) begin
            cnt_d = period_d - CNT_W'(1);
        end else begin
            cnt_d  = atWrap_o ? '0 : cnt_q + CNT_W'(1);
            clk_d  = (cnt_d < high_q);
            tick_d = (cnt_d == period_q - CNT_W'(1));
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            period_q <= RESET_P;
            high_q   <= RESET_HI;
            cnt_q    <= RESET_P - CNT_W'(1);
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            high_q   <= high_d;
            cnt_q    <= cnt_d;
            clk_q    <= clk_d;
            tick_q   <= tick_d;
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider with a single-slot, wrap-synchronised
// configuration port. Define DUTY_EN to add a programmable high count (cfg_duty).
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  CNT_W       = 26,
    parameter int  DEFAULT_DIV = 50000000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
`ifdef DUTY_EN
    input  logic [CNT_W-1:0]  cfg_duty,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    cfg_state_e       state_q, state_d;
    logic [CH_W-1:0]  pendCh_q, pendCh_d;
    logic [CNT_W-1:0] pendDiv_q, pendDiv_d;
    logic [CNT_W-1:0] pendHi_q, pendHi_d;
    logic [CNT_W-1:0] divNew;
    logic [CNT_W-1:0] hiNew;
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] atWrap;
    logic             applyNow;
    logic             targetValid;
    logic             targetEn;
    logic             targetWrap;

    assign cfg_ready = (state_q == IDLE);
    assign divNew    = CNT_W'(clampU32(32'(cfg_div), DIV_MIN, 32'hFFFF_FFFF));
`ifdef DUTY_EN
    assign hiNew     = CNT_W'(clampU32(32'(cfg_duty), 32'd1, 32'(divNew) - 32'd1));
`else
    assign hiNew     = divNew >> 1;
`endif

    // Out-of-range channel numbers (NUM_CH not a power of two) match nothing
    // and are simply dropped.
    always_comb begin
        targetValid = 1'b0;
        targetEn    = 1'b0;
        targetWrap  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pendCh_q == CH_W'(i)) begin
                targetValid = 1'b1;
                targetEn    = enable[i];
                targetWrap  = atWrap[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pendCh_d  = pendCh_q;
        pendDiv_d = pendDiv_q;
        pendHi_d  = pendHi_q;
        applyNow  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    state_d   = WAIT_WRAP;
                    pendCh_d  = cfg_ch;
                    pendDiv_d = divNew;
                    pendHi_d  = hiNew;
                end
            end
            WAIT_WRAP: begin
                if (!targetValid) begin
                    state_d = IDLE;
                end else if (!targetEn || targetWrap) begin
                    applyNow = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i] = applyNow && (pendCh_q == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pendCh_q  <= '0;
            pendDiv_q <= '0;
            pendHi_q  <= '0;
        end else begin
            state_q   <= state_d;
            pendCh_q  <= pendCh_d;
            pendDiv_q <= pendDiv_d;
            pendHi_q  <= pendHi_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clk_in    (clk_in),
            .reset     (reset),
            .enable_i  (enable[g]),
            .load_i    (load[g]),
            .loadDiv_i (pendDiv_q),
            .loadHi_i  (pendHi_q),
            .clk_out_o (clk_out[g]),
            .tick_o    (tick[g]),
            .atWrap_o  (atWrap[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed scenarios plus random traffic, all
// checked against a queue-based model of each channel's expected waveform.
module tb_clk_div_multi;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [0:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [CNT_W-1:0]  cfg_duty;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: each enabled channel emits one queued period at a time,
    // refilled from P/HI whenever it runs dry.
    int         mP [NUM_CH];
    int         mHi [NUM_CH];
    int         expQ [NUM_CH][$];
    bit         mReady;
    int         mPendCh, mPendDiv, mPendHi;
    logic [1:0] expClk, expTick;
    logic       expReady;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef DUTY_EN
        .cfg_duty  (cfg_duty),
`endif
        .clk_out   (clk_out),
        .tick      (tick)
    );

    always #5 clk_in = ~clk_in;

    function automatic int hiFor(input int p, input int duty);
`ifdef DUTY_EN
        if (duty < 1) return 1;
        if (duty > p - 1) return p - 1;
        return duty;
`else
        return p / 2;
`endif
    endfunction

    task automatic modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            mP[c]  = DEFAULT_DIV;
            mHi[c] = DEFAULT_DIV / 2;
            expQ[c].delete();
        end
        mReady   = 1'b1;
        expClk   = '0;
        expTick  = '0;
        expReady = 1'b1;
    endtask

    task automatic modelEdge();
        bit accept;
        int t;
        int v;
        accept = cfg_valid && mReady;
        if (!mReady) begin
            t = mPendCh;
            if (!enable[t] || expQ[t].size() == 0) begin
                mP[t]  = mPendDiv;
                mHi[t] = mPendHi;
                mReady = 1'b1;
            end
        end
        if (accept) begin
            mPendCh  = int'(cfg_ch);
            mPendDiv = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
            mPendHi  = hiFor(mPendDiv, int'(cfg_duty));
            mReady   = 1'b0;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (!enable[c]) begin
                expQ[c].delete();
                expClk[c]  = 1'b0;
                expTick[c] = 1'b0;
            end else begin
                if (expQ[c].size() == 0) begin
                    for (int k = 0; k < mP[c]; k++) begin
                        expQ[c].push_back(((k < mHi[c]) ? 2 : 0) | ((k == mP[c] - 1) ? 1 : 0));
                    end
                end
                v = expQ[c].pop_front();
                expClk[c]  = v[1];
                expTick[c] = v[0];
            end
        end
        expReady = mReady;
    endtask

    task automatic stepCycle();
        @(posedge clk_in);
        modelEdge();
        #1;
    endtask

    task automatic doReset();
        cfg_valid = 1'b0;
        enable    = '0;
        reset     = 1'b1;
        modelReset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_duty  = '0;
        enable    = '0;
        reset     = 1'b1;
        modelReset();
        #3;
        nCompared++;
        if (clk_out !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_clk: got %b want 00", clk_out);
        end
        nCompared++;
        if (tick !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_tick: got %b want 00", tick);
        end
        nCompared++;
        if (cfg_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL reset_ready: got %b want 1", cfg_ready);
        end
        reset = 1'b0;
        stepCycle();
        nCompared++;
        if (clk_out !== 2'b00 || tick !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle: got clk=%b tick=%b want 00/00", clk_out, tick);
        end
    endtask

    task automatic test_basic();
        enable = 2'b01;
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out !== {1'b0, (k % 4) < 2} || tick !== {1'b0, (k % 4) == 3}) begin
                nMismatched++;
                $display("[TB] FAIL basic_pattern k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                         k, clk_out, tick, {1'b0, (k % 4) < 2}, {1'b0, (k % 4) == 3});
            end
        end
    endtask

    task automatic test_reconfig();
        enable = 2'b00;
        stepCycle();
        enable = 2'b01;
        stepCycle();
        stepCycle();
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd6;
        stepCycle();
        cfg_valid = 1'b0;
        nCompared++;
        if (cfg_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reconfig_busy: got ready=%b want 0", cfg_ready);
        end
        stepCycle();
        nCompared++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b1 || cfg_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reconfig_old_end: got clk=%b tick=%b ready=%b want 0/1/0",
                     clk_out[0], tick[0], cfg_ready);
        end
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out[0] !== ((k % 6) < 3) || tick[0] !== ((k % 6) == 5) || cfg_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL reconfig_div6 k=%0d: got clk=%b tick=%b ready=%b want clk=%b tick=%b ready=1",
                         k, clk_out[0], tick[0], cfg_ready, (k % 6) < 3, (k % 6) == 5);
            end
        end
    endtask

    task automatic test_clamp();
        int waited;
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd1;
        stepCycle();
        cfg_valid = 1'b0;
        waited = 0;
        while (!mReady && waited < 30) begin
            stepCycle();
            waited++;
            nCompared++;
            if (clk_out !== expClk || tick !== expTick || cfg_ready !== expReady) begin
                nMismatched++;
                $display("[TB] FAIL clamp_wait: got clk=%b tick=%b ready=%b want clk=%b tick=%b ready=%b",
                         clk_out, tick, cfg_ready, expClk, expTick, expReady);
            end
        end
        if (!mReady) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL clamp_timeout: got no apply within %0d cycles want apply", waited);
        end
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out[0] !== ((k % 2) == 1) || tick[0] !== ((k % 2) == 0)) begin
                nMismatched++;
                $display("[TB] FAIL clamp_div2 k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                         k, clk_out[0], tick[0], (k % 2) == 1, (k % 2) == 0);
            end
        end
    endtask

    task automatic test_enable_drop();
        doReset();
        enable = 2'b01;
        stepCycle();
        stepCycle();
        enable = 2'b00;
        stepCycle();
        nCompared++;
        if (clk_out[0] !== 1'b0 || tick[0] !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL drop_idle: got clk=%b tick=%b want 0/0", clk_out[0], tick[0]);
        end
        stepCycle();
        stepCycle();
        enable = 2'b01;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out[0] !== ((k % 4) < 2) || tick[0] !== ((k % 4) == 3)) begin
                nMismatched++;
                $display("[TB] FAIL drop_restart k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                         k, clk_out[0], tick[0], (k % 4) < 2, (k % 4) == 3);
            end
        end
    endtask

    task automatic test_ignore_and_reset();
        int waited;
        doReset();
        enable = 2'b01;
        stepCycle();
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd8;
        stepCycle();
        cfg_ch  = 1'b1;
        cfg_div = 8'd3;
        stepCycle();
        cfg_valid = 1'b0;
        nCompared++;
        if (cfg_ready !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL ignore_busy: got ready=%b want 0", cfg_ready);
        end
        waited = 0;
        while (!mReady && waited < 30) begin
            stepCycle();
            waited++;
        end
        nCompared++;
        if (!mReady || cfg_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL ignore_apply: got ready=%b after %0d cycles want 1", cfg_ready, waited);
        end
        enable = 2'b11;
        for (int k = 0; k < 12; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out[1] !== ((k % 4) < 2) || tick[1] !== ((k % 4) == 3)) begin
                nMismatched++;
                $display("[TB] FAIL ignore_ch1 k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                         k, clk_out[1], tick[1], (k % 4) < 2, (k % 4) == 3);
            end
        end
        cfg_valid = 1'b1;
        cfg_ch    = 1'b0;
        cfg_div   = 8'd10;
        stepCycle();
        cfg_valid = 1'b0;
        #2;
        reset = 1'b1;
        modelReset();
        #1;
        nCompared++;
        if (cfg_ready !== 1'b1 || clk_out !== 2'b00 || tick !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL wait_reset: got ready=%b clk=%b tick=%b want 1/00/00", cfg_ready, clk_out, tick);
        end
        reset  = 1'b0;
        enable = 2'b01;
        for (int k = 0; k < 8; k++) begin
            stepCycle();
            nCompared++;
            if (clk_out !== {1'b0, (k % 4) < 2} || cfg_ready !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL post_reset_p4 k=%0d: got clk=%b ready=%b want clk=%b ready=1",
                         k, clk_out, cfg_ready, {1'b0, (k % 4) < 2});
            end
        end
    endtask

`ifdef DUTY_EN
    task automatic test_duty();
        int dutyIn [3] = '{1, 0, 7};
        int hiExp  [3] = '{1, 1, 4};
        int waited;
        doReset();
        enable = 2'b01;
        for (int n = 0; n < 3; n++) begin
            cfg_valid = 1'b1;
            cfg_ch    = 1'b0;
            cfg_div   = 8'd5;
            cfg_duty  = 8'(dutyIn[n]);
            stepCycle();
            cfg_valid = 1'b0;
            waited = 0;
            while (!mReady && waited < 30) begin
                stepCycle();
                waited++;
            end
            for (int k = 0; k < 10; k++) begin
                stepCycle();
                nCompared++;
                if (clk_out[0] !== (((k + 1) % 5) < hiExp[n]) || tick[0] !== (((k + 1) % 5) == 4)) begin
                    nMismatched++;
                    $display("[TB] FAIL duty%0d k=%0d: got clk=%b tick=%b want clk=%b tick=%b",
                             dutyIn[n], k, clk_out[0], tick[0], ((k + 1) % 5) < hiExp[n], ((k + 1) % 5) == 4);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        doReset();
        enable = 2'b11;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) == 0) enable = 2'($urandom_range(0, 3));
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = 8'($urandom_range(0, 12));
            cfg_duty  = 8'($urandom_range(0, 14));
            stepCycle();
            nCompared++;
            if (clk_out !== expClk || tick !== expTick || cfg_ready !== expReady) begin
                nMismatched++;
                $display("[TB] FAIL random k=%0d: got clk=%b tick=%b ready=%b want clk=%b tick=%b ready=%b",
                         k, clk_out, tick, cfg_ready, expClk, expTick, expReady);
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reconfig();
        test_clamp();
        test_enable_drop();
        test_ignore_and_reset();
`ifdef DUTY_EN
        test_duty();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
